// File: rtl/wb_inst_responder.sv
// Wishbone B3 slave that answers core reads from a driver-fed instruction FIFO
// and acks core writes while exposing them on a one-cycle store-capture port.
module wb_inst_responder #(
  parameter int          DEPTH     = 16,
  parameter int          ACK_LAT   = 1,
  parameter logic [31:0] FILL_WORD = 32'hF0081003,
  parameter int          STRICT    = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [31:0]                i_wb_adr,
  input  logic [15:0]                i_wb_sel,
  input  logic                       i_wb_we,
  input  logic [127:0]               i_wb_dat,
  input  logic                       i_wb_cyc,
  input  logic                       i_wb_stb,
  output logic [127:0]               o_wb_dat,
  output logic                       o_wb_ack,
  output logic                       o_wb_err,
  input  logic [31:0]                i_inst,
  input  logic                       i_inst_valid,
  output logic                       o_inst_ready,
  output logic [$clog2(DEPTH):0]     o_fifo_count,
  output logic                       o_st_valid,
  output logic [31:0]                o_st_adr,
  output logic [127:0]               o_st_dat,
  output logic [15:0]                o_st_sel
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic           we_q;
  logic [31:0]    adr_q;
  logic [15:0]    sel_q;
  logic [127:0]   dat_q;

  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nxt;
  logic           push;
  logic           fire;
  logic           pop;
  logic           empty;

  assign empty     = (count == '0);
  assign push      = i_inst_valid & o_inst_ready;
  assign fire      = (state == WAIT) && i_wb_cyc && (cnt == 4'd0);
  // The pop uses the pre-edge occupancy, so a same-edge push is never bypassed
  assign pop       = fire && !we_q && !empty;
  assign count_nxt = count + CW'(push) - CW'(pop);

  assign o_fifo_count = count;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_inst;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      o_inst_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count        <= count_nxt;
      o_inst_ready <= count_nxt < CW'(DEPTH);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      sel_q      <= '0;
      dat_q      <= '0;
      o_wb_dat   <= '0;
      o_wb_ack   <= 1'b0;
      o_wb_err   <= 1'b0;
      o_st_valid <= 1'b0;
      o_st_adr   <= '0;
      o_st_dat   <= '0;
      o_st_sel   <= '0;
    end else begin
      o_wb_ack   <= 1'b0;
      o_wb_err   <= 1'b0;
      o_st_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            we_q  <= i_wb_we;
            adr_q <= i_wb_adr;
            sel_q <= i_wb_sel;
            dat_q <= i_wb_dat;
            cnt   <= 4'(ACK_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!i_wb_cyc) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state <= RESP;
            if (we_q) begin
              o_wb_ack   <= 1'b1;
              o_wb_dat   <= '0;
              o_st_valid <= 1'b1;
              o_st_adr   <= adr_q;
              o_st_dat   <= dat_q;
              o_st_sel   <= sel_q;
            end else if (empty) begin
              o_wb_dat <= {4{FILL_WORD}};
              if (STRICT != 0) o_wb_err <= 1'b1;
              else             o_wb_ack <= 1'b1;
            end else begin
              o_wb_dat <= {FILL_WORD, FILL_WORD, FILL_WORD, mem[rd_ptr]};
              o_wb_ack <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_inst_responder.sv
// Random and directed checks of wb_inst_responder against a queue-based model,
// using a fast permissive instance and a slow STRICT instance.
module tb_wb_inst_responder;

  localparam logic [31:0] FILL = 32'hF0081003;
  localparam int LAT [2] = '{1, 4};
  localparam int DEP [2] = '{16, 4};
  localparam int STR [2] = '{0, 1};

  logic         clk;
  logic         rst_n [2];
  logic [31:0]  adr   [2];
  logic [15:0]  sel   [2];
  logic         wen   [2];
  logic [127:0] wdat  [2];
  logic         cyc   [2];
  logic         stb   [2];
  logic [127:0] rdat  [2];
  logic         ack   [2];
  logic         err   [2];
  logic [31:0]  inst  [2];
  logic         vld   [2];
  logic         rdy   [2];
  logic [4:0]   fc    [2];
  logic [2:0]   fc1;
  logic         stv   [2];
  logic [31:0]  sadr  [2];
  logic [127:0] sdat  [2];
  logic [15:0]  ssel  [2];

  int vectors = 0;
  int miss    = 0;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  assign fc[1] = {2'b00, fc1};

  wb_inst_responder #(
    .DEPTH(16), .ACK_LAT(1), .FILL_WORD(FILL), .STRICT(0)
  ) u0 (
    .i_clk(clk), .i_rst_n(rst_n[0]),
    .i_wb_adr(adr[0]), .i_wb_sel(sel[0]), .i_wb_we(wen[0]),
    .i_wb_dat(wdat[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]),
    .o_wb_dat(rdat[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0]),
    .i_inst(inst[0]), .i_inst_valid(vld[0]), .o_inst_ready(rdy[0]),
    .o_fifo_count(fc[0]), .o_st_valid(stv[0]), .o_st_adr(sadr[0]),
    .o_st_dat(sdat[0]), .o_st_sel(ssel[0])
  );

  wb_inst_responder #(
    .DEPTH(4), .ACK_LAT(4), .FILL_WORD(FILL), .STRICT(1)
  ) u1 (
    .i_clk(clk), .i_rst_n(rst_n[1]),
    .i_wb_adr(adr[1]), .i_wb_sel(sel[1]), .i_wb_we(wen[1]),
    .i_wb_dat(wdat[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]),
    .o_wb_dat(rdat[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1]),
    .i_inst(inst[1]), .i_inst_valid(vld[1]), .o_inst_ready(rdy[1]),
    .o_fifo_count(fc1), .o_st_valid(stv[1]), .o_st_adr(sadr[1]),
    .o_st_dat(sdat[1]), .o_st_sel(ssel[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int msize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [31:0] mfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic mpush(input int d, input logic [31:0] w);
    if (d == 0) q0.push_back(w);
    else        q1.push_back(w);
  endtask

  task automatic mpop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic mclear(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic chk_zero(input int d);
    chk("z_ack", ack[d], 0);
    chk("z_err", err[d], 0);
    chk("z_stv", stv[d], 0);
    chk("z_rdy", rdy[d], 0);
    chk("z_cnt", fc[d], 0);
    chk("z_rdat", rdat[d], 0);
    chk("z_st", {sadr[d], ssel[d], sdat[d][79:0]}, 0);
  endtask

  task automatic push_word(input int d, input logic [31:0] w);
    bit r;
    r = msize(d) < DEP[d];
    inst[d] = w;
    vld[d]  = 1'b1;
    chk("push_rdy", rdy[d], r);
    tick();
    if (r) mpush(d, w);
    chk("push_cnt", fc[d], msize(d));
  endtask

  task automatic burst(input int d, input int n);
    for (int i = 0; i < n; i++) push_word(d, $urandom);
    vld[d] = 1'b0;
  endtask

  task automatic xfer(input int d, input bit we, input logic [31:0] a,
                      input logic [15:0] s, input logic [127:0] wd,
                      input bit pa);
    int n;
    bit got, empty, rdy_m, eerr;
    logic [31:0]  h;
    logic [127:0] exd;
    cyc[d] = 1'b1; stb[d] = 1'b1; wen[d] = we;
    adr[d] = a; sel[d] = s; wdat[d] = wd;
    tick();
    n = 0; got = 0; empty = 1; h = '0;
    while (!got && n < LAT[d] + 4) begin
      if (n == LAT[d] - 1) begin
        empty = (msize(d) == 0);
        if (!empty) h = mfront(d);
        if (pa) begin
          inst[d] = $urandom;
          vld[d]  = 1'b1;
        end
      end
      rdy_m = msize(d) < DEP[d];
      tick();
      n++;
      got = ack[d] | err[d];
      if (got && !we && !empty) mpop(d);
      if (vld[d]) begin
        if (rdy_m) mpush(d, inst[d]);
        vld[d] = 1'b0;
      end
    end
    chk("resp", got, 1);
    chk("lat", n, LAT[d]);
    eerr = !we && empty && (STR[d] != 0);
    chk("ack", ack[d], !eerr);
    chk("err", err[d], eerr);
    exd = we ? '0 : empty ? {4{FILL}} : {FILL, FILL, FILL, h};
    chk("rdata", rdat[d], exd);
    chk("stv", stv[d], we);
    if (we) begin
      chk("st_adr", sadr[d], a);
      chk("st_sel", ssel[d], s);
      chk("st_dat", sdat[d], wd);
    end
    chk("count", fc[d], msize(d));
    chk("ready", rdy[d], msize(d) < DEP[d]);
    cyc[d] = 1'b0; stb[d] = 1'b0; wen[d] = 1'b0;
    tick();
    chk("drop", {ack[d], err[d], stv[d]}, 0);
  endtask

  task automatic rd(input int d, input bit pa);
    xfer(d, 1'b0, $urandom, 16'hFFFF, '0, pa);
  endtask

  task automatic release_rst(input int d);
    rst_n[d] = 1'b1;
    chk("rel_rdy0", rdy[d], 0);
    tick();
    chk("rel_rdy1", rdy[d], 1);
    chk("rel_cnt", fc[d], 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; adr[d] = '0; sel[d] = '0; wen[d] = 1'b0;
      wdat[d] = '0; cyc[d] = 1'b0; stb[d] = 1'b0;
      inst[d] = '0; vld[d] = 1'b0;
    end
    tick();
    tick();
    chk_zero(0);
    chk_zero(1);
    release_rst(0);
    release_rst(1);

    push_word(0, 32'hE3A01005);
    push_word(0, 32'hE2811001);
    vld[0] = 1'b0;
    chk("cnt2", fc[0], 2);
    rd(0, 0);
    rd(0, 0);
    chk("cnt0", fc[0], 0);

    rd(0, 0);
    rd(1, 0);

    xfer(0, 1'b1, 32'h100, 16'h000F, {96'h0, 32'hDEADBEEF}, 0);

    burst(0, 17);
    chk("full_cnt", fc[0], 16);
    rd(0, 0);
    for (int i = 0; i < 15; i++) rd(0, 0);
    chk("drained", fc[0], 0);

    rd(0, 1);
    rd(0, 0);

    // Abort: cyc dropped while waiting on the slow instance
    burst(1, 2);
    cyc[1] = 1'b1; stb[1] = 1'b1; wen[1] = 1'b0;
    tick();
    tick();
    cyc[1] = 1'b0; stb[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort", {ack[1], err[1], stv[1]}, 0);
    end
    chk("abort_cnt", fc[1], msize(1));
    rd(1, 0);
    rd(1, 0);
    rd(1, 0);

    // Reset while waiting with three words queued
    burst(1, 3);
    cyc[1] = 1'b1; stb[1] = 1'b1; wen[1] = 1'b0;
    tick();
    tick();
    rst_n[1] = 1'b0;
    #1;
    chk_zero(1);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    mclear(1);
    tick();
    release_rst(1);

    for (int i = 0; i < 80; i++) begin
      int d;
      d = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: burst(d, $urandom_range(1, 5));
        1: rd(d, 0);
        2: xfer(d, 1'b1, $urandom, 16'($urandom),
                {$urandom, $urandom, $urandom, $urandom}, 0);
        default: rd(d, 1);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
